hist_accum: RTL and testbench

Histogram accumulator sitting directly downstream of the histogram component selector. It counts occurrences of each 8-bit component value over one frame into a 256-bin on-chip counter memory, using a read-modify-write pipeline with same-bin forwarding. On frame end it streams all 256 bins out over a valid/ready interface and clears each bin as it is read, leaving the memory ready for the next frame.

---
 rtl/hist_accum.sv | 118 +++++++++++
 tb/tb_hist_accum.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_accum.sv
// Per-frame 256-bin histogram of 8-bit component values, accumulated through a
// read-modify-write pipeline and streamed out with clear-on-read at frame end.
module hist_accum #(
  parameter int CNT_W = 21
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_frame,
  input  logic             pix_valid,
  input  logic [7:0]       pix_comp,
  input  logic             frame_end,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [7:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic             hist_last,
  output logic             busy,
  output logic             drop_err
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_DUMP
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       idx;
  logic             drain_cnt;

  logic [CNT_W-1:0] mem [256];
  logic [CNT_W-1:0] ram_q;
  logic [7:0]       rd_addr, wr_addr;
  logic             we;
  logic [CNT_W-1:0] wr_data;

  logic             s1_valid, s2_valid;
  logic [7:0]       s1_addr, s2_addr;
  logic [CNT_W-1:0] s2_data, operand, inc;
  logic             beat_done;

  // Dump handshake: a beat transfers on any cycle with hist_valid && hist_ready;
  // hist_valid never drops and the beat never changes until that happens.
  assign hist_valid = (state == S_DUMP);
  assign beat_done  = hist_valid && hist_ready;
  assign hist_bin   = hist_valid ? idx : 8'd0;
  assign hist_count = hist_valid ? ram_q : '0;
  assign hist_last  = hist_valid && (idx == 8'hFF);
  assign busy       = (state == S_CLEAR) || (state == S_DRAIN) || (state == S_DUMP);

  // S2 wrote the same bin on the edge where S1's read was taken, so the RAM
  // returned the pre-write value; take the in-flight result instead.
  assign operand = (s2_valid && (s2_addr == s1_addr)) ? s2_data : ram_q;
  assign inc     = (&operand) ? operand : operand + CNT_W'(1);

  // In DUMP the read runs one bin ahead on a handshake so the next beat is ready.
  assign rd_addr = (state == S_ACCUM) ? pix_comp : (beat_done ? idx + 8'd1 : idx);

  always_comb begin
    we      = 1'b0;
    wr_addr = idx;
    wr_data = '0;
    if (state == S_CLEAR) begin
      we = 1'b1;
    end else if (s1_valid) begin
      we      = 1'b1;
      wr_addr = s1_addr;
      wr_data = inc;
    end else if (beat_done) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    ram_q <= mem[rd_addr];
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_CLEAR: if (idx == 8'hFF) state_nxt = S_IDLE;
      S_IDLE:  if (start_frame) state_nxt = S_ACCUM;
      S_ACCUM: if (frame_end) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt) state_nxt = S_DUMP;
      S_DUMP:  if (beat_done && (idx == 8'hFF)) state_nxt = S_IDLE;
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_CLEAR;
      idx       <= 8'd0;
      drain_cnt <= 1'b0;
      s1_valid  <= 1'b0;
      s1_addr   <= 8'd0;
      s2_valid  <= 1'b0;
      s2_addr   <= 8'd0;
      s2_data   <= '0;
      drop_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      // idx wraps 255->0 at the end of CLEAR and DUMP, so IDLE always sees 0
      if ((state == S_CLEAR) || beat_done) idx <= idx + 8'd1;
      drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
      s1_valid  <= pix_valid && (state == S_ACCUM);
      s1_addr   <= pix_comp;
      s2_valid  <= s1_valid;
      s2_addr   <= s1_addr;
      s2_data   <= inc;
      drop_err  <= pix_valid && busy;
    end
  end

endmodule

// File: tb/tb_hist_accum.sv
// Directed bench for hist_accum: a 21-bit and a 4-bit instance share stimulus,
// and every dump is checked against a hand-built histogram.
module tb_hist_accum;
  localparam int CNT_W = 21;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start_frame, pix_valid, frame_end, hist_ready;
  logic [7:0]       pix_comp;
  logic             hist_valid, hist_last, busy, drop_err;
  logic [7:0]       hist_bin;
  logic [CNT_W-1:0] hist_count;
  logic             h4_valid, h4_last, h4_busy, h4_drop;
  logic [7:0]       h4_bin;
  logic [3:0]       h4_count;

  int               n_checks = 0;
  int               n_fail   = 0;
  int unsigned      hist [256];
  logic [CNT_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  hist_accum #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start_frame(start_frame), .pix_valid(pix_valid),
    .pix_comp(pix_comp), .frame_end(frame_end), .hist_valid(hist_valid),
    .hist_ready(hist_ready), .hist_bin(hist_bin), .hist_count(hist_count),
    .hist_last(hist_last), .busy(busy), .drop_err(drop_err)
  );

  hist_accum #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start_frame(start_frame), .pix_valid(pix_valid),
    .pix_comp(pix_comp), .frame_end(frame_end), .hist_valid(h4_valid),
    .hist_ready(hist_ready), .hist_bin(h4_bin), .hist_count(h4_count),
    .hist_last(h4_last), .busy(h4_busy), .drop_err(h4_drop)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    int n;
    reset_n = 1'b0;
    #1;
    check("rst_hist_valid", hist_valid, 0);
    check("rst_hist_bin", hist_bin, 0);
    check("rst_hist_count", hist_count, 0);
    check("rst_hist_last", hist_last, 0);
    check("rst_drop_err", drop_err, 0);
    check("rst_busy", busy, 1);
    check("rst_busy4", h4_busy, 1);
    tick;
    tick;
    reset_n = 1'b1;
    n = 0;
    while (busy && n < 300) begin
      tick;
      n++;
    end
    check("clear_cycles", n, 256);
    check("busy_after_clear", busy, 0);
  endtask

  task automatic begin_frame;
    foreach (hist[i]) hist[i] = 0;
    start_frame = 1'b1;
    tick;
    start_frame = 1'b0;
  endtask

  task automatic send_pix(input logic [7:0] v, input logic fe);
    pix_valid = 1'b1;
    pix_comp  = v;
    frame_end = fe;
    tick;
    pix_valid = 1'b0;
    frame_end = 1'b0;
    hist[v]++;
  endtask

  task automatic end_frame;
    frame_end = 1'b1;
    tick;
    frame_end = 1'b0;
  endtask

  // Call right after the frame_end cycle. bp toggles hist_ready every cycle;
  // drop_a/drop_b inject a pixel in DUMP; abort_at asserts reset at that bin.
  task automatic dump(input bit bp, input int drop_a, input int drop_b, input int abort_at);
    int lat;
    logic [CNT_W-1:0] e;
    logic [3:0] e4;
    bit drop_pend;
    hist_ready = bp ? 1'b0 : 1'b1;
    lat = 1;
    while (!hist_valid && lat < 10) begin
      tick;
      lat++;
    end
    check("first_valid_latency_le4", lat <= 4, 1);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(CNT_W'(hist[i]));
    drop_pend = 1'b0;
    for (int b = 0; b < 256; b++) begin
      e  = exp_q.pop_front();
      e4 = (e > 15) ? 4'd15 : e[3:0];
      check($sformatf("valid_b%0d", b), hist_valid, 1);
      check($sformatf("bin_b%0d", b), hist_bin, b);
      check($sformatf("count_b%0d", b), hist_count, e);
      check($sformatf("last_b%0d", b), hist_last, (b == 255));
      check($sformatf("bin4_b%0d", b), h4_bin, b);
      check($sformatf("count4_b%0d", b), h4_count, e4);
      check($sformatf("drop_b%0d", b), drop_err, drop_pend);
      if (b == abort_at) begin
        reset_n = 1'b0;
        hist_ready = 1'b0;
        #1;
        check("abort_valid", hist_valid, 0);
        check("abort_busy", busy, 1);
        return;
      end
      if (bp) begin
        hist_ready = 1'b0;
        tick;
        check($sformatf("stall_valid_b%0d", b), hist_valid, 1);
        check($sformatf("stall_bin_b%0d", b), hist_bin, b);
        check($sformatf("stall_count_b%0d", b), hist_count, e);
        check($sformatf("stall_last_b%0d", b), hist_last, (b == 255));
        hist_ready = 1'b1;
        tick;
      end else begin
        drop_pend = (b == drop_a) || (b == drop_b);
        if (drop_pend) begin
          pix_valid = 1'b1;
          pix_comp  = 8'h10;
        end
        tick;
        pix_valid = 1'b0;
      end
    end
    check("after_dump_valid", hist_valid, 0);
    check("after_dump_busy", busy, 0);
    check("after_dump_valid4", h4_valid, 0);
    check("after_dump_drop", h4_drop, drop_pend);
    hist_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    start_frame = 1'b0;
    pix_valid = 1'b0;
    frame_end = 1'b0;
    hist_ready = 1'b0;
    pix_comp = 8'h00;

    // Reset, then an empty frame
    do_reset();
    begin_frame();
    end_frame();
    dump(1'b0, -1, -1, -1);

    // Pixels and frame_end in IDLE are ignored without error
    pix_valid = 1'b1;
    pix_comp  = 8'h05;
    frame_end = 1'b1;
    tick;
    pix_valid = 1'b0;
    frame_end = 1'b0;
    tick;
    check("idle_drop_err", drop_err, 0);
    check("idle_busy", busy, 0);

    // Same-bin forwarding
    begin_frame();
    for (int i = 0; i < 10; i++) send_pix(8'h05, 1'b0);
    end_frame();
    dump(1'b0, -1, -1, -1);

    // Alternating values, a gap, then a run ending on the frame_end cycle
    begin_frame();
    for (int i = 0; i < 1000; i++) send_pix((i % 2 == 0) ? 8'h00 : 8'hFF, 1'b0);
    tick;
    tick;
    tick;
    for (int i = 0; i < 499; i++) send_pix(8'h80, 1'b0);
    send_pix(8'h80, 1'b1);
    check("alt_bin0_model", hist[0], 500);
    dump(1'b0, -1, -1, -1);

    // Backpressure twice on identical frames; start_frame mid-frame is ignored
    for (int f = 0; f < 2; f++) begin
      begin_frame();
      for (int i = 0; i < 60; i++) begin
        if (i == 20) start_frame = 1'b1;
        send_pix(8'((i * 37) % 256), 1'b0);
        start_frame = 1'b0;
        if (i % 3 == 0) send_pix(8'h2A, 1'b0);
      end
      end_frame();
      dump(1'b1, -1, -1, -1);
    end

    // Saturation of the 4-bit instance
    begin_frame();
    for (int i = 0; i < 20; i++) send_pix(8'h33, 1'b0);
    end_frame();
    dump(1'b0, -1, -1, -1);

    // Pixels offered during DUMP are dropped and do not leak into the next frame
    begin_frame();
    for (int i = 0; i < 3; i++) send_pix(8'h10, 1'b0);
    end_frame();
    dump(1'b0, 10, 20, -1);
    begin_frame();
    for (int i = 0; i < 2; i++) send_pix(8'h10, 1'b0);
    end_frame();
    dump(1'b0, -1, -1, -1);

    // Reset in the middle of a dump discards the partial histogram
    begin_frame();
    for (int i = 0; i < 7; i++) send_pix(8'hC8, 1'b0);
    end_frame();
    dump(1'b0, -1, -1, 100);
    do_reset();
    begin_frame();
    for (int i = 0; i < 3; i++) send_pix(8'h64, 1'b0);
    send_pix(8'h01, 1'b1);
    dump(1'b0, -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
